// File: rtl/bus_ram_responder_pkg.sv
// Shared constants for data-bus responders: FSM states,
// default wait counts and the window select decode.
package bus_ram_responder_pkg;

  typedef enum logic [1:0] {
    BUSRAM_IDLE = 2'd0,
    BUSRAM_WAIT = 2'd1,
    BUSRAM_DONE = 2'd2
  } busram_state_e;

  localparam int BUSRAM_RD_WAIT_DEF = 2;
  localparam int BUSRAM_WR_WAIT_DEF = 1;
  localparam int BUSRAM_CNT_W       = 4;

  typedef logic [BUSRAM_CNT_W-1:0] cnt_t;

  // Window is 4*2^aw bytes and base is window-aligned, so
  // selection only compares the bits above the window.
  function automatic logic busram_sel(
    input logic        req,
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          aw
  );
    return req && ((addr >> (aw + 2)) == (base >> (aw + 2)));
  endfunction

endpackage

// File: rtl/bus_ram_array.sv
// Single-port 32-bit RAM, 2^ADDR_WIDTH words, registered read.
// Ports: clk, we/re enables, addr, wdata in, rdata out.
module bus_ram_array
  import bus_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_ram_responder.sv
// RAM target for the rd_req/wr_req/rw_wait data bus with fixed
// wait states; rd_data is zero unless completing a read.
// Ports: clk, Nrst (async low), busaddr, rd_req, wr_req,
// wr_data in; rd_data, rw_wait out.
// Option: BUSRAM_POSTED_WR_EN adds a 1-entry posted write buffer.
module bus_ram_responder
  import bus_ram_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_WAIT    = BUSRAM_RD_WAIT_DEF,
  parameter int          WR_WAIT    = BUSRAM_WR_WAIT_DEF
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] busaddr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rw_wait
);

  typedef logic [ADDR_WIDTH-1:0] waddr_t;

  // cnt holds stall cycles left in WAIT, including the current one
  localparam cnt_t RD_LD = cnt_t'(RD_WAIT - 1);
`ifdef BUSRAM_POSTED_WR_EN
  localparam cnt_t WR_CNT = cnt_t'(WR_WAIT);
`else
  localparam cnt_t WR_LD = cnt_t'((WR_WAIT > 1) ? WR_WAIT - 1 : 1);
`endif

  busram_state_e state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  waddr_t        addr_q, addr_d;
  logic          is_rd_q, is_rd_d;

  logic        req, sel;
  waddr_t      word;
  logic        ram_we, ram_re;
  waddr_t      ram_addr;
  logic [31:0] ram_wdata, ram_rdata, rd_word;

  assign req  = rd_req | wr_req;
  assign sel  = busram_sel(req, busaddr, BASE_ADDR, ADDR_WIDTH);
  assign word = busaddr[ADDR_WIDTH+1:2];

`ifdef BUSRAM_POSTED_WR_EN
  logic        pb_valid_q, pb_valid_d;
  waddr_t      pb_addr_q, pb_addr_d;
  logic [31:0] pb_data_q, pb_data_d;
  cnt_t        pb_cnt_q, pb_cnt_d;
  logic        fwd_q, fwd_d;
  logic [31:0] fwd_data_q, fwd_data_d;
  logic        pb_load, pb_retire;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_rd_d   = is_rd_q;
    rw_wait   = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wr_data;
`ifdef BUSRAM_POSTED_WR_EN
    pb_load   = 1'b0;
    pb_retire = 1'b0;
`endif
    unique case (state_q)
      BUSRAM_IDLE: begin
        if (sel && rd_req) begin
          rw_wait = 1'b1;
          addr_d  = word;
          is_rd_d = 1'b1;
          if (RD_WAIT == 1) begin
            ram_re   = 1'b1;
            ram_addr = word;
            state_d  = BUSRAM_DONE;
          end else begin
            cnt_d   = RD_LD;
            state_d = BUSRAM_WAIT;
          end
        end else if (sel) begin
`ifdef BUSRAM_POSTED_WR_EN
          // stall until the previous posted write has retired
          if (pb_valid_q) rw_wait = 1'b1;
          else            pb_load = 1'b1;
`else
          addr_d  = word;
          is_rd_d = 1'b0;
          if (WR_WAIT == 0) begin
            ram_we   = 1'b1;
            ram_addr = word;
          end else begin
            rw_wait = 1'b1;
            if (WR_WAIT == 1) begin
              state_d = BUSRAM_DONE;
            end else begin
              cnt_d   = WR_LD;
              state_d = BUSRAM_WAIT;
            end
          end
`endif
        end
      end
      BUSRAM_WAIT: begin
        if (!req) begin
          state_d = BUSRAM_IDLE;
        end else begin
          rw_wait = 1'b1;
          if (cnt_q == cnt_t'(1)) begin
            ram_re  = is_rd_q;
            state_d = BUSRAM_DONE;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
      end
      BUSRAM_DONE: begin
        state_d = BUSRAM_IDLE;
`ifndef BUSRAM_POSTED_WR_EN
        // a write flushed in its completion cycle is dropped
        ram_we  = !is_rd_q && wr_req;
`endif
      end
      default: state_d = BUSRAM_IDLE;
    endcase
`ifdef BUSRAM_POSTED_WR_EN
    // reads own the single port; retirement waits a cycle
    if (!ram_re && pb_valid_q && pb_cnt_q <= cnt_t'(1)) begin
      pb_retire = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = pb_addr_q;
      ram_wdata = pb_data_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= BUSRAM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
    end
  end

`ifdef BUSRAM_POSTED_WR_EN
  always_comb begin
    pb_valid_d = pb_valid_q;
    pb_addr_d  = pb_addr_q;
    pb_data_d  = pb_data_q;
    pb_cnt_d   = pb_cnt_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    if (pb_valid_q && pb_cnt_q != '0) pb_cnt_d = pb_cnt_q - cnt_t'(1);
    if (pb_retire) pb_valid_d = 1'b0;
    if (pb_load) begin
      pb_valid_d = 1'b1;
      pb_addr_d  = word;
      pb_data_d  = wr_data;
      pb_cnt_d   = WR_CNT;
    end
    // a read hitting the pending word takes the buffer data
    if (ram_re) begin
      fwd_d      = pb_valid_q && (pb_addr_q == ram_addr);
      fwd_data_d = pb_data_q;
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      pb_valid_q <= 1'b0;
      pb_addr_q  <= '0;
      pb_data_q  <= '0;
      pb_cnt_q   <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      pb_valid_q <= pb_valid_d;
      pb_addr_q  <= pb_addr_d;
      pb_data_q  <= pb_data_d;
      pb_cnt_q   <= pb_cnt_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rd_word = fwd_q ? fwd_data_q : ram_rdata;
`else
  assign rd_word = ram_rdata;
`endif

  assign rd_data = (state_q == BUSRAM_DONE && is_rd_q) ? rd_word : '0;

  bus_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench for bus_ram_responder: a driver queues the
// expected completion, a negedge monitor checks the bus.
module tb_bus_ram_responder;

  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          RDW  = 2;
  localparam int          WRW  = 1;
  localparam logic [31:0] WIN  = 32'(4 * (1 << AW));

  logic        clk = 1'b0;
  logic        Nrst = 1'b1;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] busaddr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rw_wait;

  always #5 clk = ~clk;

  bus_ram_responder #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .RD_WAIT   (RDW),
    .WR_WAIT   (WRW)
  ) dut (
    .clk    (clk),
    .Nrst   (Nrst),
    .busaddr(busaddr),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .rw_wait(rw_wait)
  );

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  logic [31:0] mem_m [int];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_m = 0;
  int busy_last = -100;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a - BASE) < WIN;
  endfunction

  // monitor: a completion is any requesting cycle without stall
  always @(negedge clk) begin
    if (!Nrst) begin
      stall_m = 0;
    end else if (rd_req || wr_req) begin
      if (rw_wait) begin
        stall_m++;
        check("rd_data_in_stall", rd_data, 32'h0);
      end else begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_completion: got rd_data %h with no access queued", rd_data);
        end else begin
          e_m = sb.pop_front();
          check({e_m.nm, "_data"}, rd_data, e_m.rdata);
          check({e_m.nm, "_stall"}, 32'(stall_m), 32'(e_m.stall));
        end
        stall_m = 0;
      end
    end else begin
      check("idle_rw_wait", {31'h0, rw_wait}, 32'h0);
      check("idle_rd_data", rd_data, 32'h0);
      stall_m = 0;
    end
  end

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (!rw_wait) break;
      c++;
      if (c > 40) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: rw_wait still 1 after %0d cycles, required 0", nm, c);
        break;
      end
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input string nm);
    exp_t e;
    int   w;
    int   st;
    w = int'((a - BASE) >> 2);
    e.nm = nm;
    e.rdata = '0;
    e.stall = 0;
    if ((rd || wr) && in_win(a)) begin
      if (rd) begin
        e.rdata = mem_m.exists(w) ? mem_m[w] : 32'h0;
        e.stall = RDW;
      end else begin
`ifdef BUSRAM_POSTED_WR_EN
        st = busy_last - cyc + 1;
        if (st < 0) st = 0;
        e.stall = st;
        busy_last = cyc + st + ((WRW > 1) ? WRW : 1);
`else
        st = WRW;
        e.stall = st;
`endif
        mem_m[w] = d;
      end
    end
    sb.push_back(e);
    rd_req = rd;
    wr_req = wr;
    busaddr = a;
    wr_data = d;
    wait_done(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int          c0;
  int          k;
  logic [31:0] ra;
  logic [31:0] rv;

  initial begin
    #1 Nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rw_wait", {31'h0, rw_wait}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    @(negedge clk);
    Nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++)
      drive(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, "init_wr");
    idle(2);

    drive(1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, "wr_10");
    idle(1);
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0, "rd_10");
    idle(1);

    c0 = cyc;
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b0, BASE + 32'h20 + 32'(4 * i), 32'h0, "b2b_rd");
    check("b2b_cycles", 32'(cyc - c0), 32'(4 * (RDW + 1)));
    idle(1);

    drive(1'b1, 1'b0, BASE + WIN, 32'h0, "oor_rd");
    drive(1'b0, 1'b1, BASE + WIN + 32'h10, 32'hA5A5A5A5, "oor_wr");
    idle(1);
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0, "rd_10_after_oor");
    idle(1);

    drive(1'b1, 1'b1, BASE + 32'h50, 32'h0BADF00D, "rw_both");
    idle(1);
    drive(1'b1, 1'b0, BASE + 32'h50, 32'h0, "rd_50_after_both");
    idle(1);

`ifndef BUSRAM_POSTED_WR_EN
    wr_req = 1'b1;
    busaddr = BASE + 32'h40;
    wr_data = 32'h12345678;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    idle(2);
    drive(1'b1, 1'b0, BASE + 32'h40, 32'h0, "rd_40_after_abort");
    idle(1);

    wr_req = 1'b1;
    busaddr = BASE + 32'h44;
    wr_data = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    Nrst = 1'b0;
    wr_req = 1'b0;
    #1;
    check("rst_wr_rw_wait", {31'h0, rw_wait}, 32'h0);
    @(negedge clk);
    #2 Nrst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, BASE + 32'h44, 32'h0, "rd_44_after_rst");
    idle(1);
`endif

    sb.push_back('{nm: "rst_done_rd", rdata: mem_m[4], stall: RDW});
    rd_req = 1'b1;
    busaddr = BASE + 32'h10;
    wait_done("rst_done_rd");
    #1;
    Nrst = 1'b0;
    rd_req = 1'b0;
    #1;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rw_wait", {31'h0, rw_wait}, 32'h0);
    @(negedge clk);
    #2 Nrst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, BASE + 32'h10, 32'h0, "rd_10_after_rst");
    idle(1);

`ifdef BUSRAM_POSTED_WR_EN
    drive(1'b0, 1'b1, BASE + 32'h60, 32'h600DCAFE, "pw_60");
    drive(1'b1, 1'b0, BASE + 32'h60, 32'h0, "pw_rd_60");
    idle(WRW + 2);
    drive(1'b0, 1'b1, BASE + 32'h64, 32'h64646464, "pw_64");
    drive(1'b0, 1'b1, BASE + 32'h68, 32'h68686868, "pw_68");
    idle(WRW + 2);
    drive(1'b1, 1'b0, BASE + 32'h64, 32'h0, "pw_rd_64");
    drive(1'b1, 1'b0, BASE + 32'h68, 32'h0, "pw_rd_68");
    idle(1);
`endif

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 19));
      ra = BASE + 32'(4 * $urandom_range(0, 31));
      rv = $urandom;
      if (k < 9) begin
        drive(1'b1, 1'b0, ra, 32'h0, "rnd_rd");
      end else if (k < 17) begin
        drive(1'b0, 1'b1, ra, rv, "rnd_wr");
`ifdef BUSRAM_POSTED_WR_EN
        idle(WRW + 1);
`endif
      end else if (k < 18) begin
        drive(1'b1, 1'b1, ra, rv, "rnd_both");
      end else begin
        drive(1'b1, 1'b0, BASE + WIN + ra, 32'h0, "rnd_oor");
      end
      if ($urandom_range(0, 1) == 1)
        idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
